mips_decode_alu_unit: RTL and testbench
=======================================

Name: mips_decode_alu_unit

Overview:
- Combines three units of the 5-stage MIPS pipeline into one block:
  - main control decoder (ID stage),
  - branch equality comparator (ID stage),
  - 32-bit ALU (EX stage).
- Decoder and comparator are purely combinational.
- The ALU provides a combinational result for forwarding, plus a registered copy for the EX/ME boundary.

Parameters:
- WIDTH, 32, datapath width for the comparator and ALU operands/results. Only 32 is supported.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- op  in  6  instr[31:26] of the ID-stage instruction
- funct  in  6  instr[5:0] of the ID-stage instruction
- ctrl_alu  out  4  ALU operation code (encoding below)
- ctrl_regdst  out  1  1 = write rd; 0 = write rt
- ctrl_alusrca  out  2  ALU A source: 0 rs, 1 constant 16 (lui), 2 shamt
- ctrl_alusrcb  out  2  ALU B source: 0 rt, 1 extended immediate
- ctrl_mem2reg  out  1  1 = writeback from memory
- ctrl_ext  out  1  1 = sign-extend imm16; 0 = zero-extend
- ctrl_regwr  out  1  register file write enable
- ctrl_memwr  out  1  data memory write enable
- ctrl_branch  out  2  01 beq, 10 bne, 00 none
- ctrl_jump  out  1  j instruction
- cond_a  in  32  forwarded rs value
- cond_b  in  32  forwarded rt value
- equal  out  1  cond_a == cond_b
- alu_a  in  32  ALU operand A (post source mux)
- alu_b  in  32  ALU operand B (post source mux)
- aluop  in  4  EX-stage ALU op
- alu_out  out  32  combinational ALU result
- alu_out_q  out  32  alu_out registered on rising clk

Behaviour:

ALU op encoding (alu_out, combinational):
- 0 ADD: a+b
- 1 SUB: a-b
- 2 AND
- 3 OR
- 4 XOR
- 5 NOR
- 6 SLT: signed a<b gives 1, else 0
- 7 SLTU: unsigned compare, same output convention as SLT
- 8 SLL: b << a[4:0]
- 9 SRL: b >> a[4:0], logical
- 10 SRA: b >>> a[4:0], arithmetic
- 11..15: result 0
- ADD/SUB wrap modulo 2^32; no overflow flag, no trap.
- Shifts use only a[4:0]; upper bits of a are ignored.

Registered output and reset:
- alu_out_q <= alu_out on each rising clk; one-cycle latency.
- rst asserted (any time, asynchronously): alu_out_q = 0 immediately, held while rst=1.
- All other outputs are combinational and unaffected by rst.

Comparator:
- equal = 1 iff all 32 bits match, including 0 == 0.

Decoder, R-type (op=000000), selected by funct. All R-type: regdst=1, regwr=1, alusrcb=0, ext=0.
- 0x20/0x21 add/addu → ADD
- 0x22/0x23 sub/subu → SUB
- 0x24 → AND
- 0x25 → OR
- 0x26 → XOR
- 0x27 → NOR
- 0x2A → SLT
- 0x2B → SLTU
- 0x00/0x02/0x03 sll/srl/sra → SLL/SRL/SRA, alusrca=2 (shamt)
- 0x04/0x06/0x07 sllv/srlv/srav → SLL/SRL/SRA, alusrca=0
- Unlisted funct: all outputs 0.

Decoder, I-type and J-type. Defaults unless stated: regdst=0, alusrca=0, alusrcb=1.
- 0x08 addi: ADD, ext=1, regwr=1
- 0x09 addiu: ADD, ext=1, regwr=1
- 0x0A slti: SLT, ext=1, regwr=1
- 0x0B sltiu: SLTU, ext=1, regwr=1
- 0x0C andi: AND, ext=0, regwr=1
- 0x0D ori: OR, ext=0, regwr=1
- 0x0E xori: XOR, ext=0, regwr=1
- 0x0F lui: SLL, alusrca=1, ext=0, regwr=1
- 0x23 lw: ADD, ext=1, regwr=1, mem2reg=1
- 0x2B sw: ADD, ext=1, memwr=1, regwr=0
- 0x04 beq: branch=01, ext=1, alusrcb=0, regwr=0
- 0x05 bne: branch=10, ext=1, alusrcb=0, regwr=0
- 0x02 j: jump=1, everything else 0
- Any other op: every control output 0 (bubble).
- Instruction 0x00000000 decodes as sll r0,r0,0. Writing r0 is harmless.

Decomposition:
- Shared package holds:
  - ALU op localparams (ALU_ADD…ALU_SRA),
  - opcode and funct constants,
  - ALU source-select encodings,
  - branch encodings (BR_NONE/BR_EQ/BR_NE).
- One sub-module is natural: mips_alu_core (the combinational ALU).
- Decoder and comparator stay inline.

Test Plan:
- rst=1 mid-run with alu_out_q=0x1234 → alu_out_q=0 immediately without a clk edge. After release, next edge loads alu_out.
- ALU ops:
  - ADD 0xFFFFFFFF+1 → 0
  - SUB 0-1 → 0xFFFFFFFF
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0
  - SRA a=4, b=0x80000000 → 0xF8000000
  - SLL a=0x24 (uses 4), b=1 → 0x10
  - aluop=13 → 0
- Decode:
  - add (op=0, funct=0x20) → regdst=1, regwr=1, ctrl_alu=0, srcA=0, srcB=0
  - lw (0x23) → mem2reg=1, regwr=1, srcB=1, ext=1
  - sw (0x2B) → memwr=1, regwr=0
  - lui (0x0F) → alu=SLL, srcA=1, srcB=1, ext=0
- Decode beq=01 and bne=10 with regwr=0; j → only jump=1; op=0x3F → all control outputs 0.
- Comparator: 0x5A5A5A5A vs 0x5A5A5A5A → equal=1; flip bit 31 → equal=0.
- Registered path: alu_a=3, alu_b=4, aluop=ADD → alu_out=7 same cycle, alu_out_q=7 after next rising edge.

Source files
------------

// File: rtl/mips_decode_alu_unit_pkg.sv
// Shared constants and types for the MIPS decode/ALU slice.
// Holds ALU op codes, opcodes, funct codes and control bundle layout.
package mips_decode_alu_unit_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] SRCA_RS    = 2'd0;
    localparam logic [1:0] SRCA_C16   = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_RT  = 2'd0;
    localparam logic [1:0] SRCB_IMM = 2'd1;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    typedef struct packed {
        logic [3:0] alu;
        logic       regdst;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       mem2reg;
        logic       ext;
        logic       regwr;
        logic       memwr;
        logic [1:0] branch;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Common shape of every R-type that is recognised.
    function automatic ctrl_t rtype(input logic [3:0] alu,
                                    input logic [1:0] srca);
        ctrl_t c;
        c         = CTRL_NOP;
        c.alu     = alu;
        c.regdst  = 1'b1;
        c.alusrca = srca;
        c.alusrcb = SRCB_RT;
        c.regwr   = 1'b1;
        return c;
    endfunction

    // Common shape of immediate-operand I-types that write rt.
    function automatic ctrl_t itype(input logic [3:0] alu,
                                    input logic       ext);
        ctrl_t c;
        c         = CTRL_NOP;
        c.alu     = alu;
        c.alusrca = SRCA_RS;
        c.alusrcb = SRCB_IMM;
        c.ext     = ext;
        c.regwr   = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/mips_decode_alu_unit_alu_core.sv
// Combinational 32-bit MIPS ALU.
// Shift amount comes from a[4:0]; unused op codes yield zero.
module mips_alu_core
    import mips_decode_alu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    output logic [WIDTH-1:0] y
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = a[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // Select the result for the requested operation.
    always_comb begin
        y = '0;
        unique case (aluop)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: y = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_SRA:  y = $signed(b) >>> shamt;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/mips_decode_alu_unit.sv
// ID-stage control decoder and branch comparator plus EX-stage ALU.
// Only the ALU result register is clocked; everything else is combinational.
module mips_decode_alu_unit
    import mips_decode_alu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    output logic [3:0]       ctrl_alu,
    output logic             ctrl_regdst,
    output logic [1:0]       ctrl_alusrca,
    output logic [1:0]       ctrl_alusrcb,
    output logic             ctrl_mem2reg,
    output logic             ctrl_ext,
    output logic             ctrl_regwr,
    output logic             ctrl_memwr,
    output logic [1:0]       ctrl_branch,
    output logic             ctrl_jump,
    input  logic [WIDTH-1:0] cond_a,
    input  logic [WIDTH-1:0] cond_b,
    output logic             equal,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       aluop,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_q
);

    ctrl_t ctrl;
    ctrl_t rctrl;

    // R-type funct decode; unknown funct becomes a bubble.
    always_comb begin
        rctrl = CTRL_NOP;
        unique case (funct)
            FN_ADD, FN_ADDU: rctrl = rtype(ALU_ADD, SRCA_RS);
            FN_SUB, FN_SUBU: rctrl = rtype(ALU_SUB, SRCA_RS);
            FN_AND:  rctrl = rtype(ALU_AND, SRCA_RS);
            FN_OR:   rctrl = rtype(ALU_OR, SRCA_RS);
            FN_XOR:  rctrl = rtype(ALU_XOR, SRCA_RS);
            FN_NOR:  rctrl = rtype(ALU_NOR, SRCA_RS);
            FN_SLT:  rctrl = rtype(ALU_SLT, SRCA_RS);
            FN_SLTU: rctrl = rtype(ALU_SLTU, SRCA_RS);
            FN_SLL:  rctrl = rtype(ALU_SLL, SRCA_SHAMT);
            FN_SRL:  rctrl = rtype(ALU_SRL, SRCA_SHAMT);
            FN_SRA:  rctrl = rtype(ALU_SRA, SRCA_SHAMT);
            FN_SLLV: rctrl = rtype(ALU_SLL, SRCA_RS);
            FN_SRLV: rctrl = rtype(ALU_SRL, SRCA_RS);
            FN_SRAV: rctrl = rtype(ALU_SRA, SRCA_RS);
            default: rctrl = CTRL_NOP;
        endcase
    end

    // Opcode decode; unknown opcode becomes a bubble.
    always_comb begin
        ctrl = CTRL_NOP;
        unique case (op)
            OP_RTYPE: ctrl = rctrl;
            OP_ADDI:  ctrl = itype(ALU_ADD, 1'b1);
            OP_ADDIU: ctrl = itype(ALU_ADD, 1'b1);
            OP_SLTI:  ctrl = itype(ALU_SLT, 1'b1);
            OP_SLTIU: ctrl = itype(ALU_SLTU, 1'b1);
            OP_ANDI:  ctrl = itype(ALU_AND, 1'b0);
            OP_ORI:   ctrl = itype(ALU_OR, 1'b0);
            OP_XORI:  ctrl = itype(ALU_XOR, 1'b0);
            OP_LUI: begin
                ctrl         = itype(ALU_SLL, 1'b0);
                ctrl.alusrca = SRCA_C16;
            end
            OP_LW: begin
                ctrl         = itype(ALU_ADD, 1'b1);
                ctrl.mem2reg = 1'b1;
            end
            OP_SW: begin
                ctrl       = itype(ALU_ADD, 1'b1);
                ctrl.regwr = 1'b0;
                ctrl.memwr = 1'b1;
            end
            OP_BEQ: begin
                ctrl.ext    = 1'b1;
                ctrl.branch = BR_EQ;
            end
            OP_BNE: begin
                ctrl.ext    = 1'b1;
                ctrl.branch = BR_NE;
            end
            OP_J:     ctrl.jump = 1'b1;
            default:  ctrl = CTRL_NOP;
        endcase
    end

    assign ctrl_alu     = ctrl.alu;
    assign ctrl_regdst  = ctrl.regdst;
    assign ctrl_alusrca = ctrl.alusrca;
    assign ctrl_alusrcb = ctrl.alusrcb;
    assign ctrl_mem2reg = ctrl.mem2reg;
    assign ctrl_ext     = ctrl.ext;
    assign ctrl_regwr   = ctrl.regwr;
    assign ctrl_memwr   = ctrl.memwr;
    assign ctrl_branch  = ctrl.branch;
    assign ctrl_jump    = ctrl.jump;

    assign equal = (cond_a == cond_b);

    mips_alu_core #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .aluop (aluop),
        .y     (alu_out)
    );

    // EX/ME pipeline copy of the ALU result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_out;
        end
    end

endmodule

// File: tb/tb_mips_decode_alu_unit.sv
// Directed testbench for mips_decode_alu_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_mips_decode_alu_unit;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [3:0]  ctrl_alu;
    logic        ctrl_regdst;
    logic [1:0]  ctrl_alusrca;
    logic [1:0]  ctrl_alusrcb;
    logic        ctrl_mem2reg;
    logic        ctrl_ext;
    logic        ctrl_regwr;
    logic        ctrl_memwr;
    logic [1:0]  ctrl_branch;
    logic        ctrl_jump;
    logic [31:0] cond_a;
    logic [31:0] cond_b;
    logic        equal;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  aluop;
    logic [31:0] alu_out;
    logic [31:0] alu_out_q;

    int checks = 0;
    int errors = 0;

    mips_decode_alu_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .funct        (funct),
        .ctrl_alu     (ctrl_alu),
        .ctrl_regdst  (ctrl_regdst),
        .ctrl_alusrca (ctrl_alusrca),
        .ctrl_alusrcb (ctrl_alusrcb),
        .ctrl_mem2reg (ctrl_mem2reg),
        .ctrl_ext     (ctrl_ext),
        .ctrl_regwr   (ctrl_regwr),
        .ctrl_memwr   (ctrl_memwr),
        .ctrl_branch  (ctrl_branch),
        .ctrl_jump    (ctrl_jump),
        .cond_a       (cond_a),
        .cond_b       (cond_b),
        .equal        (equal),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .aluop        (aluop),
        .alu_out      (alu_out),
        .alu_out_q    (alu_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle: alu,regdst,srca,srcb,m2r,ext,regwr,memwr,br,j
    logic [15:0] ctrl_obs;
    assign ctrl_obs = {ctrl_alu, ctrl_regdst, ctrl_alusrca, ctrl_alusrcb,
                       ctrl_mem2reg, ctrl_ext, ctrl_regwr, ctrl_memwr,
                       ctrl_branch, ctrl_jump};

    task automatic test_reset;
        rst   = 1'b1;
        alu_a = 32'h0;
        alu_b = 32'h0;
        aluop = 4'd0;
        #2;
        checks++;
        if (alu_out_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", alu_out_q, 32'h0);
        end
        @(negedge clk);
        rst   = 1'b0;
        alu_a = 32'h1234;
        alu_b = 32'h0;
        aluop = 4'd0;
        @(posedge clk);
        #1;
        checks++;
        if (alu_out_q !== 32'h1234) begin
            errors++;
            $display("FAIL reset_preload: got %h want %h", alu_out_q, 32'h1234);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (alu_out_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", alu_out_q, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (alu_out_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", alu_out_q, 32'h0);
        end
        @(negedge clk);
        rst   = 1'b0;
        alu_a = 32'h55;
        @(posedge clk);
        #1;
        checks++;
        if (alu_out_q !== 32'h55) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", alu_out_q, 32'h55);
        end
    endtask

    task automatic test_alu_ops;
        logic [31:0] va [12];
        logic [31:0] vb [12];
        logic [3:0]  vo [12];
        logic [31:0] vy [12];
        va = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h4, 32'h24, 32'h1234, 32'hF0F0F0F0,
               32'hFF00FF00, 32'h0, 32'h4, 32'h3};
        vb = '{32'h1, 32'h1, 32'h1, 32'h1,
               32'h80000000, 32'h1, 32'h5678, 32'h0FF00FF0,
               32'h0F0F0F0F, 32'h0, 32'h80000000, 32'h3};
        vo = '{4'd0, 4'd1, 4'd6, 4'd7,
               4'd10, 4'd8, 4'd13, 4'd2,
               4'd4, 4'd5, 4'd9, 4'd1};
        vy = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0,
               32'hF8000000, 32'h10, 32'h0, 32'h00F000F0,
               32'hF00FF00F, 32'hFFFFFFFF, 32'h08000000, 32'h0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            alu_a = va[i];
            alu_b = vb[i];
            aluop = vo[i];
            #1;
            checks++;
            if (alu_out !== vy[i]) begin
                errors++;
                $display("FAIL alu_op%0d[%0d]: got %h want %h",
                         vo[i], i, alu_out, vy[i]);
            end
        end
    endtask

    task automatic test_decode;
        logic [5:0]  vop [15];
        logic [5:0]  vfn [15];
        logic [15:0] vex [15];
        vop = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                6'h23, 6'h2B, 6'h0F, 6'h04, 6'h05,
                6'h02, 6'h3F, 6'h0D, 6'h0A, 6'h00};
        vfn = '{6'h20, 6'h22, 6'h00, 6'h07, 6'h01,
                6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00,
                6'h00, 6'h20, 6'h00, 6'h00, 6'h2B};
        // {alu,regdst,srca,srcb,m2r,ext,regwr,memwr,br,j}
        vex = '{{4'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0},
                {4'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0},
                {4'd8, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0},
                {4'd10, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0},
                16'h0000,
                {4'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0},
                {4'd0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0},
                {4'd8, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0},
                {4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0},
                {4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0},
                16'h0001,
                16'h0000,
                {4'd3, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0},
                {4'd6, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0},
                {4'd7, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0}};
        for (int i = 0; i < 15; i++) begin
            op    = vop[i];
            funct = vfn[i];
            #1;
            checks++;
            if (ctrl_obs !== vex[i]) begin
                errors++;
                $display("FAIL decode op=%h funct=%h: got %h want %h",
                         vop[i], vfn[i], ctrl_obs, vex[i]);
            end
        end
    endtask

    task automatic test_compare;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        ve [4];
        va = '{32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0, 32'h00000001};
        vb = '{32'h5A5A5A5A, 32'hDA5A5A5A, 32'h0, 32'h00000000};
        ve = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            cond_a = va[i];
            cond_b = vb[i];
            #1;
            checks++;
            if (equal !== ve[i]) begin
                errors++;
                $display("FAIL compare[%0d] %h vs %h: got %b want %b",
                         i, va[i], vb[i], equal, ve[i]);
            end
        end
    endtask

    task automatic test_registered;
        @(negedge clk);
        alu_a = 32'd3;
        alu_b = 32'd4;
        aluop = 4'd0;
        #1;
        checks++;
        if (alu_out !== 32'd7) begin
            errors++;
            $display("FAIL reg_comb: got %h want %h", alu_out, 32'd7);
        end
        checks++;
        if (alu_out_q === 32'd7) begin
            errors++;
            $display("FAIL reg_early: got %h want not %h", alu_out_q, 32'd7);
        end
        @(posedge clk);
        #1;
        checks++;
        if (alu_out_q !== 32'd7) begin
            errors++;
            $display("FAIL reg_q: got %h want %h", alu_out_q, 32'd7);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q;
        @(negedge clk);
        alu_a = 32'd10;
        alu_b = 32'd3;
        aluop = 4'd1;
        @(posedge clk);
        #1;
        exp_q = 32'd7;
        checks++;
        if (alu_out_q !== exp_q) begin
            errors++;
            $display("FAIL b2b_0: got %h want %h", alu_out_q, exp_q);
        end
        alu_a = 32'd1;
        alu_b = 32'h80000000;
        aluop = 4'd9;
        @(posedge clk);
        #1;
        exp_q = 32'h40000000;
        checks++;
        if (alu_out_q !== exp_q) begin
            errors++;
            $display("FAIL b2b_1: got %h want %h", alu_out_q, exp_q);
        end
    endtask

    initial begin
        rst    = 1'b1;
        op     = 6'h0;
        funct  = 6'h0;
        cond_a = 32'h0;
        cond_b = 32'h0;
        alu_a  = 32'h0;
        alu_b  = 32'h0;
        aluop  = 4'h0;
        test_reset();
        test_alu_ops();
        test_decode();
        test_compare();
        test_registered();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
